wide_add_sequencer: RTL and testbench

//  Sequences the shared 11-bit ripple adder (ElevenBitFullAdder) to perform one

---
 rtl/wide_add_pkg.sv | 12 +
 rtl/wide_add_sequencer_if.sv | 30 +++
 rtl/ElevenBitFullAdder.sv | 12 +
 rtl/wide_add_sequencer.sv | 125 ++++++++++++
 tb/tb_wide_add_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/wide_add_pkg.sv
// Shared definitions for the sliced wide adder: slice width and sequencer states.
package wide_add_pkg;

    localparam int unsigned SLICE_W = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Request/result bundle between a client and the wide add sequencer.
interface wide_add_sequencer_if
    import wide_add_pkg::*;
#(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = WORDS * SLICE_W;

    logic         start;
    logic         op_sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, op_sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/ElevenBitFullAdder.sv
// Shared 11-bit ripple adder used one slice at a time by the sequencer.
module ElevenBitFullAdder (
    input  logic [10:0] A,
    input  logic [10:0] B,
    input  logic        Cin,
    output logic [10:0] Sum,
    output logic        Cout
);

    assign {Cout, Sum} = 12'(A) + 12'(B) + 12'(Cin);

endmodule

// File: rtl/wide_add_sequencer.sv
// Performs one WORDS*11-bit add/subtract by stepping the 11-bit adder over the
// operand slices LSB first, carrying between slices in a register.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wide_add_sequencer_if.slave  bus
);

    localparam int unsigned W     = WORDS * SLICE_W;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t             state;
    state_t             state_nxt;
    logic               accept_c;
    logic               last_c;

    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       sum_r;
    logic               busy_r;
    logic               done_r;
    logic               cout_r;
    logic               ovf_r;

    logic [SLICE_W-1:0] sa_c;
    logic [SLICE_W-1:0] sb_c;
    logic [SLICE_W-1:0] ssum_c;
    logic               scout_c;

    assign last_c = (idx == IDX_W'(WORDS - 1));
    assign sa_c   = a_r[idx*SLICE_W +: SLICE_W];
    assign sb_c   = b_r[idx*SLICE_W +: SLICE_W];

    ElevenBitFullAdder u_slice_add (
        .A    (sa_c),
        .B    (sb_c),
        .Cin  (carry_r),
        .Sum  (ssum_c),
        .Cout (scout_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a new op may be accepted in FIN as well as IDLE
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    accept_c  = 1'b1;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    accept_c  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, slice stepping and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sum_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            busy_r <= (state_nxt == RUN);
            done_r <= (state_nxt == FIN);
            if (accept_c) begin
                a_r     <= bus.a;
                b_r     <= bus.op_sub ? ~bus.b : bus.b;
                carry_r <= bus.op_sub ? 1'b1 : bus.cin;
                idx     <= '0;
            end else if (state == RUN) begin
                sum_r[idx*SLICE_W +: SLICE_W] <= ssum_c;
                carry_r <= scout_c;
                if (last_c) begin
                    cout_r <= scout_c;
                    // carry into the MSB is recovered from the MSB sum bit
                    ovf_r  <= scout_c ^ ssum_c[SLICE_W-1] ^ sa_c[SLICE_W-1] ^ sb_c[SLICE_W-1];
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of the wide add sequencer at WORDS=4 (44-bit operands).
module tb_wide_add_sequencer;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 44;

    logic clk;
    logic rst;

    wide_add_sequencer_if #(.WORDS(WORDS)) bus ();

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent 44-bit model of the full operation
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic ci, output logic [W-1:0] s, output logic co,
                         output logic ov);
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   full;
        be   = sub ? ~b : b;
        ce   = sub ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, be} + (W+1)'(ce);
        s    = full[W-1:0];
        co   = full[W];
        ov   = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // Waits for done after an accept edge; returns cycles since the accept edge
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic ci);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           lat;
        model(a, b, sub, ci, es, ec, eo);
        bus.a      = a;
        bus.b      = b;
        bus.op_sub = sub;
        bus.cin    = ci;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        check({tag, ".busy"}, 64'(bus.busy), 64'd1);
        wait_done(lat);
        check({tag, ".lat"}, 64'(lat), 64'd5);
        check({tag, ".sum"}, 64'(bus.sum), 64'(es));
        check({tag, ".cout"}, 64'(bus.cout), 64'(ec));
        check({tag, ".ovf"}, 64'(bus.ovf), 64'(eo));
        step();
    endtask

    initial begin
        int           lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         seen_done;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.cin    = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        step();
        step();
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.sum",  64'(bus.sum),  64'd0);
        check("rst.cout", 64'(bus.cout), 64'd0);
        check("rst.ovf",  64'(bus.ovf),  64'd0);
        rst = 1'b0;
        step();

        // Carry propagation through every slice
        run_op("allones_p1", 44'hFFF_FFFF_FFFF, 44'd1, 1'b0, 1'b0);
        check("t2.sum0", 64'(bus.sum), 64'd0);
        check("t2.cout1", 64'(bus.cout), 64'd1);
        run_op("maxpos_p1", 44'h7FF_FFFF_FFFF, 44'd1, 1'b0, 1'b0);
        check("t3.sum", 64'(bus.sum), 64'h800_0000_0000);
        check("t3.ovf", 64'(bus.ovf), 64'd1);
        run_op("sub_5_7", 44'd5, 44'd7, 1'b1, 1'b0);
        check("t4.sum", 64'(bus.sum), 64'hFFF_FFFF_FFFE);
        check("t4.cout", 64'(bus.cout), 64'd0);
        run_op("sub_7_5", 44'd7, 44'd5, 1'b1, 1'b1);
        check("t4b.sum", 64'(bus.sum), 64'd2);
        check("t4b.cout", 64'(bus.cout), 64'd1);
        run_op("cin_add", 44'd10, 44'd20, 1'b0, 1'b1);
        check("cin.sum", 64'(bus.sum), 64'd31);

        // Start held while busy with changing operands; then accept in FIN
        bus.a = 44'd100; bus.b = 44'd200; bus.op_sub = 1'b0; bus.cin = 1'b0;
        bus.start = 1'b1;
        step();
        lat = 1;
        while (!bus.done && lat < 30) begin
            bus.a      = {$urandom, $urandom};
            bus.b      = {$urandom, $urandom};
            bus.op_sub = 1'($urandom);
            bus.cin    = 1'($urandom);
            step();
            lat++;
        end
        check("hold.lat", 64'(lat), 64'd5);
        check("hold.sum", 64'(bus.sum), 64'd300);
        check("hold.fin_busy", 64'(bus.busy), 64'd0);
        bus.a = 44'd1000; bus.b = 44'd2000; bus.op_sub = 1'b0; bus.cin = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("b2b.busy", 64'(bus.busy), 64'd1);
        check("b2b.done_low", 64'(bus.done), 64'd0);
        wait_done(lat);
        check("b2b.lat", 64'(lat), 64'd5);
        check("b2b.sum", 64'(bus.sum), 64'd3000);
        step();
        check("b2b.idle_busy", 64'(bus.busy), 64'd0);
        check("b2b.done_pulse", 64'(bus.done), 64'd0);

        // Reset mid-op aborts with no done pulse
        bus.a = 44'hABC_DEF0_1234; bus.b = 44'h111_1111_1111; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        check("abort.sum",  64'(bus.sum),  64'd0);
        check("abort.cout", 64'(bus.cout), 64'd0);
        check("abort.ovf",  64'(bus.ovf),  64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen_done = seen_done | bus.done;
        end
        check("abort.no_done", 64'(seen_done), 64'd0);
        run_op("post_abort", 44'd123, 44'd456, 1'b0, 1'b0);
        check("post_abort.579", 64'(bus.sum), 64'd579);

        // Reset wins over start in the same cycle
        rst = 1'b1; bus.start = 1'b1;
        step();
        rst = 1'b0; bus.start = 1'b0;
        check("rst_prio.busy", 64'(bus.busy), 64'd0);
        step();

        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 10 == 0) rb = ra;
            run_op("rand", ra, rb, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
